sync_mod_counter: RTL



---
 rtl/sync_mod_counter.sv | 94 +++++++++
 1 files changed

// File: rtl/sync_mod_counter.sv
// Synchronous modulo counter: up/down, parallel load, clear, enable prescaler,
// wrap-or-saturate at the limits, with terminal-count and overflow status.
module sync_mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf_sticky
);

    // MODULUS-1 held in WIDTH bits, so MODULUS = 2**WIDTH becomes all-ones.
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic step;
    logic at_max;
    logic at_min;
    logic hit_limit;

    generate
        if (PRESCALE > 1) begin : g_pre
            localparam int PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
            logic [PW-1:0] pre_cnt;

            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            always_ff @(posedge clk) begin
                if (reset || clear || load) begin
                    pre_cnt <= '0;
                end else if (en) begin
                    pre_cnt <= (pre_cnt == LAST) ? '0 : pre_cnt + 1'b1;
                end
            end

            assign step = en && (pre_cnt == LAST);
        end else begin : g_no_pre
            assign step = en;
        end
    endgenerate

    assign at_max    = (q == MAX);
    assign at_min    = (q == '0);
    assign tc        = up_dn ? at_max : at_min;
    // A step that reaches past a limit flags overflow whether it wraps or holds.
    assign hit_limit = step && !clear && !load && (up_dn ? at_max : at_min);

    always_ff @(posedge clk) begin
        if (reset) begin
            q          <= '0;
            wrap       <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            // NOTE: wrap is defaulted low here so it can only ever be a
            // single-cycle pulse; the branches below only raise it.
            wrap <= 1'b0;
            if (clear) begin
                q <= '0;
            end else if (load) begin
                q <= (load_val > MAX) ? MAX : load_val;
            end else if (step) begin
                if (up_dn) begin
                    if (!at_max) begin
                        q <= q + 1'b1;
                    end else if (SATURATE == 0) begin
                        q    <= '0;
                        wrap <= 1'b1;
                    end
                end else begin
                    if (!at_min) begin
                        q <= q - 1'b1;
                    end else if (SATURATE == 0) begin
                        q    <= MAX;
                        wrap <= 1'b1;
                    end
                end
            end
            // Set beats clear when both happen on the same edge.
            ovf_sticky <= hit_limit | (ovf_sticky & ~ovf_clr);
        end
    end

endmodule
